// File: rtl/maze_pkg.sv
// maze_pkg: frame geometry, ROM colour codes and shared FSM/direction types
package maze_pkg;
   localparam int FRAME_W = 96;
   localparam int FRAME_H = 64;
   localparam logic [15:0] WALL_COLOR = 16'hFFFF;
   localparam logic [15:0] GOAL_COLOR = 16'h001F;
   typedef enum logic [1:0] {DIR_UP, DIR_DOWN, DIR_LEFT, DIR_RIGHT} dir_t;
   typedef enum logic [1:0] {IDLE, SCAN, DRAIN, COMMIT} state_t;
endpackage

// File: rtl/maze_index_calc.sv
// maze_index_calc: (x,y) to 13-bit ROM address y*96+x using shift-add
module maze_index_calc (
   input  logic [6:0]  x,
   input  logic [5:0]  y,
   output logic [12:0] index
);
   assign index = {1'b0, y, 6'b0} + {2'b0, y, 5'b0} + {6'b0, x};
endmodule

// File: rtl/maze_walker.sv
// maze_walker: scans the leading edge of the player square in the maze ROM
// and commits, blocks or wins each single-step move request.
module maze_walker
   import maze_pkg::*;
#(
   parameter int PSIZE   = 3,
   parameter int START_X = 4,
   parameter int START_Y = 4
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        move_up,
   input  logic        move_down,
   input  logic        move_left,
   input  logic        move_right,
   output logic [12:0] index,
   input  logic [15:0] data,
   output logic [6:0]  player_x,
   output logic [5:0]  player_y,
   output logic        busy,
   output logic        blocked,
   output logic        win
);
   state_t      state;
   dir_t        dir, req_dir;
   logic [3:0]  k;
   logic        wall_hit, goal_hit, req, in_bounds, last;
   logic        is_wall, is_goal;
   logic [6:0]  ex;
   logic [5:0]  ey;
   logic [12:0] home_idx, edge_idx;

   maze_index_calc u_home (.x(player_x), .y(player_y), .index(home_idx));
   maze_index_calc u_edge (.x(ex), .y(ey), .index(edge_idx));

   always_comb begin
      req       = move_up | move_down | move_left | move_right;
      req_dir   = move_up ? DIR_UP : move_down ? DIR_DOWN : move_left ? DIR_LEFT : DIR_RIGHT;
      in_bounds = req_dir == DIR_UP   ? player_y != 6'd0 :
                  req_dir == DIR_DOWN ? 32'(player_y) + PSIZE < FRAME_H :
                  req_dir == DIR_LEFT ? player_x != 7'd0 :
                                        32'(player_x) + PSIZE < FRAME_W;
      ex        = dir == DIR_LEFT  ? player_x - 7'd1 :
                  dir == DIR_RIGHT ? player_x + 7'(PSIZE) : player_x + 7'(k);
      ey        = dir == DIR_UP    ? player_y - 6'd1 :
                  dir == DIR_DOWN  ? player_y + 6'(PSIZE) : player_y + 6'(k);
      index     = state == SCAN ? edge_idx : home_idx;
      busy      = state != IDLE;
      last      = k == 4'(PSIZE - 1);
      is_wall   = data == WALL_COLOR;
      is_goal   = data == GOAL_COLOR;
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state    <= IDLE;
         dir      <= DIR_UP;
         k        <= 4'd0;
         wall_hit <= 1'b0;
         goal_hit <= 1'b0;
         blocked  <= 1'b0;
         win      <= 1'b0;
         player_x <= 7'(START_X);
         player_y <= 6'(START_Y);
      end else begin
         blocked <= 1'b0;
         case (state)
            IDLE: if (req && !win) begin
               if (in_bounds) begin
                  dir      <= req_dir;
                  wall_hit <= 1'b0;
                  goal_hit <= 1'b0;
                  k        <= 4'd0;
                  state    <= SCAN;
               end else begin
                  blocked <= 1'b1;
               end
            end
            SCAN: begin
               // ROM data lags index by one cycle, so k=0 has nothing to capture yet
               if (k != 4'd0) begin
                  wall_hit <= wall_hit | is_wall;
                  goal_hit <= goal_hit | is_goal;
               end
               k <= k + 4'd1;
               if (last) state <= DRAIN;
            end
            DRAIN: begin
               wall_hit <= wall_hit | is_wall;
               goal_hit <= goal_hit | is_goal;
               blocked  <= wall_hit | is_wall;
               state    <= COMMIT;
            end
            COMMIT: begin
               if (!wall_hit) begin
                  player_x <= dir == DIR_LEFT ? player_x - 7'd1 :
                              dir == DIR_RIGHT ? player_x + 7'd1 : player_x;
                  player_y <= dir == DIR_UP ? player_y - 6'd1 :
                              dir == DIR_DOWN ? player_y + 6'd1 : player_y;
                  win      <= win | goal_hit;
               end
               state <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end
endmodule

// File: tb/tb_maze_walker.sv
// tb_maze_walker: directed vector table plus hand-written timing sequences
module tb_maze_walker;
   logic        clk = 0, reset = 1;
   logic [3:0]  mv = 4'b0;
   logic [12:0] index;
   logic [15:0] data;
   logic [6:0]  player_x;
   logic [5:0]  player_y;
   logic        busy, blocked, win;
   logic [15:0] rom [0:6143];
   int n_cmp = 0, n_err = 0;

   typedef struct {
      logic [3:0]  mv;
      int          rx, ry;
      logic [15:0] col;
      int          ex, ey, eblk, ewin;
   } vec_t;
   vec_t v [12];

   maze_walker dut (
      .clk(clk), .reset(reset),
      .move_up(mv[3]), .move_down(mv[2]), .move_left(mv[1]), .move_right(mv[0]),
      .index(index), .data(data),
      .player_x(player_x), .player_y(player_y),
      .busy(busy), .blocked(blocked), .win(win)
   );

   always #5 clk = ~clk;
   always_ff @(posedge clk) data <= rom[index];

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string name, input int act, input int exp);
      n_cmp++;
      if (act != exp) begin
         n_err++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   task automatic clear_rom();
      for (int i = 0; i < 6144; i++) rom[i] = 16'h0;
   endtask

   task automatic do_reset();
      reset = 1;
      mv = 4'b0;
      tick();
      tick();
      reset = 0;
   endtask

   task automatic do_move(input logic [3:0] m, output int nblk);
      nblk = 0;
      mv = m;
      tick();
      mv = 4'b0;
      for (int c = 1; c < 9; c++) begin
         nblk += int'(blocked);
         tick();
      end
   endtask

   initial begin
      int nb;
      v[0]  = '{4'b0001, 7, 5, 16'h0000, 5, 4, 0, 0};
      v[1]  = '{4'b0001, 7, 5, 16'hFFFF, 4, 4, 1, 0};
      v[2]  = '{4'b1000, 4, 3, 16'h0000, 4, 3, 0, 0};
      v[3]  = '{4'b1001, 7, 4, 16'hFFFF, 4, 3, 0, 0};
      v[4]  = '{4'b0100, 4, 7, 16'h001F, 4, 5, 0, 1};
      v[5]  = '{4'b0010, 3, 6, 16'hFFFF, 4, 4, 1, 0};
      v[6]  = '{4'b0010, 3, 4, 16'h001F, 3, 4, 0, 1};
      v[7]  = '{4'b0100, 6, 7, 16'hFFFF, 4, 4, 1, 0};
      v[8]  = '{4'b0110, 3, 5, 16'hFFFF, 4, 5, 0, 0};
      v[9]  = '{4'b0001, 8, 4, 16'h001F, 5, 4, 0, 0};
      v[10] = '{4'b1000, 4, 2, 16'hFFFF, 4, 3, 0, 0};
      v[11] = '{4'b1000, 6, 3, 16'hFFFF, 4, 4, 1, 0};

      clear_rom();
      do_reset();
      chk("rst_x", player_x, 4);
      chk("rst_y", player_y, 4);
      chk("rst_busy", busy, 0);
      chk("rst_win", win, 0);
      chk("rst_blocked", blocked, 0);
      chk("rst_index", index, 388);

      foreach (v[i]) begin
         clear_rom();
         rom[v[i].ry * 96 + v[i].rx] = v[i].col;
         do_reset();
         do_move(v[i].mv, nb);
         chk($sformatf("vec%0d_x", i), player_x, v[i].ex);
         chk($sformatf("vec%0d_y", i), player_y, v[i].ey);
         chk($sformatf("vec%0d_blk", i), nb, v[i].eblk);
         chk($sformatf("vec%0d_win", i), win, v[i].ewin);
      end

      // right-move latency and scan addresses on an empty maze
      clear_rom();
      do_reset();
      nb = 0;
      mv = 4'b0001;
      chk("lat_busy0", busy, 0);
      tick();
      mv = 4'b0;
      for (int c = 1; c <= 6; c++) begin
         if (c <= 3) chk($sformatf("lat_index_c%0d", c), index, 388 + 3 + (c - 1) * 96);
         chk($sformatf("lat_busy_c%0d", c), busy, (c <= 5) ? 1 : 0);
         nb += int'(blocked);
         if (c == 5) chk("lat_x_c5", player_x, 4);
         if (c == 6) chk("lat_x_c6", player_x, 5);
         tick();
      end
      chk("lat_blocked", nb, 0);

      // wall at (7,5): blocked exactly in cycle 5
      clear_rom();
      rom[5 * 96 + 7] = 16'hFFFF;
      do_reset();
      mv = 4'b0001;
      tick();
      mv = 4'b0;
      for (int c = 1; c <= 6; c++) begin
         chk($sformatf("wall_blk_c%0d", c), blocked, (c == 5) ? 1 : 0);
         tick();
      end
      chk("wall_x", player_x, 4);
      chk("wall_y", player_y, 4);

      // walk to (0,10) then a left move fails the bounds check
      clear_rom();
      do_reset();
      for (int i = 0; i < 4; i++) do_move(4'b0010, nb);
      for (int i = 0; i < 6; i++) do_move(4'b0100, nb);
      chk("edge_x", player_x, 0);
      chk("edge_y", player_y, 10);
      mv = 4'b0010;
      tick();
      mv = 4'b0;
      chk("edge_blk", blocked, 1);
      chk("edge_busy", busy, 0);
      chk("edge_index", index, 960);
      tick();
      chk("edge_blk_off", blocked, 0);
      chk("edge_x_after", player_x, 0);

      // up and right together: only the up edge is scanned
      clear_rom();
      do_reset();
      mv = 4'b1001;
      tick();
      mv = 4'b0;
      for (int c = 1; c <= 3; c++) begin
         chk($sformatf("pri_index_c%0d", c), index, 291 + c);
         tick();
      end
      for (int c = 4; c <= 6; c++) tick();
      chk("pri_x", player_x, 4);
      chk("pri_y", player_y, 3);

      // goal reached, then later moves are ignored
      clear_rom();
      rom[7 * 96 + 4] = 16'h001F;
      do_reset();
      do_move(4'b0100, nb);
      chk("goal_win", win, 1);
      chk("goal_y", player_y, 5);
      mv = 4'b0001;
      tick();
      mv = 4'b0;
      chk("goal_busy", busy, 0);
      chk("goal_blk", blocked, 0);
      for (int c = 0; c < 6; c++) tick();
      chk("goal_x_held", player_x, 4);
      chk("goal_index", index, 484);

      // reset during cycle 2 of a scan aborts the move
      clear_rom();
      do_reset();
      do_move(4'b0001, nb);
      chk("abort_pre_x", player_x, 5);
      mv = 4'b0010;
      tick();
      mv = 4'b0;
      tick();
      reset = 1;
      tick();
      reset = 0;
      chk("abort_busy", busy, 0);
      chk("abort_x", player_x, 4);
      chk("abort_y", player_y, 4);
      nb = 0;
      for (int c = 0; c < 6; c++) begin
         nb += int'(blocked) + int'(busy);
         tick();
      end
      chk("abort_quiet", nb, 0);
      chk("abort_x_after", player_x, 4);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end
endmodule
